// File: rtl/instruction_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_queue_pkg
//  Brief    : Shared state encoding and helpers for the instruction queue.
//  Revision : 1.0  initial release
// ============================================================================
package instruction_queue_pkg;

    // Controller states
    localparam logic [1:0] IQ_IDLE  = 2'd0;
    localparam logic [1:0] IQ_RUN   = 2'd1;
    localparam logic [1:0] IQ_DRAIN = 2'd2;

    // 16-bit counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_queue_if
//  Brief    : Fetch-response and decode handshake bundle of the queue.
//             master = fetch/decode side, slave = the queue itself.
//  Revision : 1.0  initial release
// ============================================================================
interface instruction_queue_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    in_valid;
    logic [DATA_WIDTH-1:0]   in_instruction;
    logic [ADDRESS_BITS-1:0] in_PC;
    logic                    stall;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_instruction;
    logic [ADDRESS_BITS-1:0] out_PC;
    logic                    decode_ready;

    modport master (
        output in_valid, in_instruction, in_PC, decode_ready,
        input  stall, out_valid, out_instruction, out_PC
    );

    modport slave (
        input  in_valid, in_instruction, in_PC, decode_ready,
        output stall, out_valid, out_instruction, out_PC
    );
endinterface
`default_nettype wire

// File: rtl/instruction_queue_storage.sv
`default_nettype none
// ============================================================================
//  Module   : iq_storage
//  Brief    : Entry array for the instruction queue. One write port, one
//             combinational read port. Data is not reset; validity of an
//             entry is tracked by the controller's count.
//  Revision : 1.0  initial release
// ============================================================================
module iq_storage #(
    parameter int DEPTH_BITS = 2,
    parameter int WIDTH      = 52
) (
    input  wire logic                  clk,
    input  wire logic                  i_wr_en,
    input  wire logic [DEPTH_BITS-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]      i_wr_data,
    input  wire logic [DEPTH_BITS-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]      o_rd_data
);
    localparam int c_DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    // Write the addressed entry when the controller enqueues
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/instruction_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_queue
//  Brief    : Fetch-to-decode decoupling buffer with early stall, sticky
//             overflow and redirect flush that drops stale fetch responses
//             until the redirect target PC arrives.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH_BITS   = 2,
    parameter int SKID         = 2
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    input  wire logic                    start,
    input  wire logic [ADDRESS_BITS-1:0] program_address,
    input  wire logic                    flush,
    input  wire logic [ADDRESS_BITS-1:0] redirect_target,
    output logic                         overflow,
    output logic      [15:0]             discarded,
    input  wire logic                    report,
    instruction_queue_if.slave           bus
);
    localparam int                  c_DEPTH       = 1 << DEPTH_BITS;
    localparam int                  c_ENTRY_W     = DATA_WIDTH + ADDRESS_BITS;
    localparam logic [DEPTH_BITS:0] c_FULL_COUNT  = (DEPTH_BITS + 1)'(c_DEPTH);
    localparam logic [DEPTH_BITS:0] c_STALL_LEVEL = (DEPTH_BITS + 1)'(c_DEPTH - SKID);

    logic [1:0]              r_state;
    logic [DEPTH_BITS-1:0]   r_rd_ptr;
    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [DEPTH_BITS:0]     r_count;
    logic [ADDRESS_BITS-1:0] r_expected_pc;
    logic                    r_overflow;
    logic [15:0]             r_discarded;

    logic [1:0]              w_state_nxt;
    logic [DEPTH_BITS-1:0]   w_rd_ptr_nxt;
    logic [DEPTH_BITS-1:0]   w_wr_ptr_nxt;
    logic [DEPTH_BITS:0]     w_count_nxt;
    logic [ADDRESS_BITS-1:0] w_expected_pc_nxt;
    logic                    w_overflow_nxt;
    logic [15:0]             w_discarded_nxt;

    logic                    w_full;
    logic                    w_deq;
    logic                    w_redirect;
    logic                    w_enq;
    logic                    w_deq_taken;
    logic [c_ENTRY_W-1:0]    w_head;

    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_deq      = bus.out_valid & bus.decode_ready;
    // A start while already running behaves as a redirect to program_address
    assign w_redirect = (r_state != IQ_IDLE) & (flush | start);

    // Next-state, pointer, count and status computation
    always_comb begin
        w_state_nxt       = r_state;
        w_rd_ptr_nxt      = r_rd_ptr;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_count_nxt       = r_count;
        w_expected_pc_nxt = r_expected_pc;
        w_overflow_nxt    = r_overflow;
        w_discarded_nxt   = r_discarded;
        w_enq             = 1'b0;
        w_deq_taken       = 1'b0;

        if (w_redirect) begin
            w_state_nxt       = IQ_DRAIN;
            w_expected_pc_nxt = flush ? redirect_target : program_address;
            w_rd_ptr_nxt      = '0;
            w_wr_ptr_nxt      = '0;
            w_count_nxt       = '0;
        end else if (start) begin
            w_state_nxt       = IQ_RUN;
            w_expected_pc_nxt = program_address;
        end else begin
            case (r_state)
                IQ_RUN: begin
                    w_enq       = bus.in_valid & (~w_full | w_deq);
                    w_deq_taken = w_deq;
                    if (bus.in_valid & w_full & ~w_deq) begin
                        w_overflow_nxt = 1'b1;
                    end
                end
                IQ_DRAIN: begin
                    if (bus.in_valid) begin
                        if (bus.in_PC == r_expected_pc) begin
                            w_enq       = 1'b1;
                            w_state_nxt = IQ_RUN;
                        end else begin
                            w_discarded_nxt = sat_inc16(r_discarded);
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_enq) begin
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end
            if (w_deq_taken) begin
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            end
            w_count_nxt = r_count + (DEPTH_BITS + 1)'(w_enq) - (DEPTH_BITS + 1)'(w_deq_taken);
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IQ_IDLE;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_expected_pc <= '0;
            r_overflow    <= 1'b0;
            r_discarded   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_count       <= w_count_nxt;
            r_expected_pc <= w_expected_pc_nxt;
            r_overflow    <= w_overflow_nxt;
            r_discarded   <= w_discarded_nxt;
        end
    end

    iq_storage #(
        .DEPTH_BITS (DEPTH_BITS),
        .WIDTH      (c_ENTRY_W)
    ) u_storage (
        .clk       (clock),
        .i_wr_en   (w_enq),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({bus.in_instruction, bus.in_PC}),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    // Head is forced to zero when no valid entry so unwritten storage never leaks out
    assign bus.out_valid       = (r_count != '0) & (r_state != IQ_IDLE);
    assign bus.out_instruction = bus.out_valid ? w_head[c_ENTRY_W-1 -: DATA_WIDTH] : '0;
    assign bus.out_PC          = bus.out_valid ? w_head[ADDRESS_BITS-1:0] : '0;
    assign bus.stall           = (r_count >= c_STALL_LEVEL) | (r_state == IQ_IDLE);
    assign overflow            = r_overflow;
    assign discarded           = r_discarded;

`ifndef SYNTHESIS
    // Status dump on request
    always_ff @(posedge clock) begin
        if (report) begin
            $display("[core %0d] iq state=%0d count=%0d rd=%0d wr=%0d expected_pc=0x%0h head_pc=0x%0h head_inst=0x%0h overflow=%0b discarded=%0d",
                     CORE, r_state, r_count, r_rd_ptr, r_wr_ptr, r_expected_pc,
                     bus.out_PC, bus.out_instruction, r_overflow, r_discarded);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_queue
//  Brief    : Self-checking bench: directed vector table for the documented
//             scenarios, then random traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_queue;
    localparam int DW = 32;
    localparam int AW = 20;

    logic          clock = 1'b0;
    logic          reset, start, flush, report;
    logic [AW-1:0] program_address, redirect_target;
    logic          overflow;
    logic [15:0]   discarded;

    always #5 clock = ~clock;

    instruction_queue_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) bus ();

    instruction_queue #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH_BITS(2), .SKID(2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .program_address (program_address),
        .flush           (flush),
        .redirect_target (redirect_target),
        .overflow        (overflow),
        .discarded       (discarded),
        .report          (report),
        .bus             (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic          rst, st, fl, iv, rdy;
        logic [AW-1:0] addr, tgt;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic          e_stall, e_ovf;
        logic [15:0]   e_disc;
    } vec_t;
    vec_t vecs[$];

    // Reference model: plain queue of PCs plus status
    logic [AW-1:0] mq[$];
    int            mst;        // 0 idle, 1 running, 2 draining after redirect
    logic [AW-1:0] m_exp;
    logic          m_ovf;
    logic [15:0]   m_disc;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] pc);
        return {12'hC0D, pc} ^ 32'h0000_5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, st, fl, iv, rdy, input logic [AW-1:0] addr, tgt,
                       input logic e_valid, input logic [AW-1:0] e_pc,
                       input logic e_stall, e_ovf, input logic [15:0] e_disc);
        vec_t v;
        v.rst = rst; v.st = st; v.fl = fl; v.iv = iv; v.rdy = rdy;
        v.addr = addr; v.tgt = tgt; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_stall = e_stall; v.e_ovf = e_ovf; v.e_disc = e_disc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, st, fl, iv, rdy, input logic [AW-1:0] addr, tgt);
        reset              = rst;
        start              = st;
        flush              = fl;
        bus.in_valid       = iv;
        bus.decode_ready   = rdy;
        program_address    = addr;
        bus.in_PC          = addr;
        bus.in_instruction = instr_of(addr);
        redirect_target    = tgt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic e_valid, input logic [AW-1:0] e_pc,
                                 input logic e_stall, e_ovf, input logic [15:0] e_disc);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(e_valid));
        check({tag, ".out_PC"}, 64'(bus.out_PC), e_valid ? 64'(e_pc) : 64'd0);
        check({tag, ".out_instruction"}, 64'(bus.out_instruction), e_valid ? 64'(instr_of(e_pc)) : 64'd0);
        check({tag, ".stall"}, 64'(bus.stall), 64'(e_stall));
        check({tag, ".overflow"}, 64'(overflow), 64'(e_ovf));
        check({tag, ".discarded"}, 64'(discarded), 64'(e_disc));
    endtask

    task automatic model_step(input logic rst, st, fl, iv, rdy, input logic [AW-1:0] addr, tgt);
        if (rst) begin
            mq.delete(); mst = 0; m_exp = '0; m_ovf = 1'b0; m_disc = '0;
        end else if (mst != 0 && (fl || st)) begin
            mq.delete(); m_exp = fl ? tgt : addr; mst = 2;
        end else if (st) begin
            mst = 1; m_exp = addr;
        end else if (mst == 1) begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (iv) begin
                if (mq.size() < 4) mq.push_back(addr);
                else m_ovf = 1'b1;
            end
        end else if (mst == 2 && iv) begin
            if (addr == m_exp) begin
                mq.push_back(addr); mst = 1;
            end else if (m_disc != 16'hFFFF) begin
                m_disc = m_disc + 16'd1;
            end
        end
    endtask

    logic          r_rst, r_st, r_fl, r_iv, r_rdy;
    logic [AW-1:0] r_addr, r_tgt, seq_pc;
    logic          e_valid;

    initial begin
        report = 1'b0;
        //   rst st fl iv rdy addr    tgt      valid pc      stall ovf disc
        add(1, 0, 0, 0, 0, 20'h000, 20'h000, 0, 20'h000, 1, 0, 0);   // reset
        add(0, 1, 0, 0, 0, 20'h100, 20'h000, 0, 20'h000, 0, 0, 0);   // start 0x100
        add(0, 0, 0, 1, 1, 20'h100, 20'h000, 1, 20'h100, 0, 0, 0);
        add(0, 0, 0, 1, 1, 20'h104, 20'h000, 1, 20'h104, 0, 0, 0);
        add(0, 0, 0, 1, 1, 20'h108, 20'h000, 1, 20'h108, 0, 0, 0);
        add(0, 0, 0, 1, 1, 20'h10C, 20'h000, 1, 20'h10C, 0, 0, 0);
        add(0, 0, 0, 0, 1, 20'h000, 20'h000, 0, 20'h000, 0, 0, 0);   // drain
        add(0, 0, 0, 1, 0, 20'h110, 20'h000, 1, 20'h110, 0, 0, 0);   // fill, decode stalled
        add(0, 0, 0, 1, 0, 20'h114, 20'h000, 1, 20'h110, 1, 0, 0);
        add(0, 0, 0, 1, 0, 20'h118, 20'h000, 1, 20'h110, 1, 0, 0);
        add(0, 0, 0, 1, 0, 20'h11C, 20'h000, 1, 20'h110, 1, 0, 0);   // full
        add(0, 0, 0, 1, 1, 20'h120, 20'h000, 1, 20'h114, 1, 0, 0);   // full enq+deq
        add(0, 0, 0, 1, 0, 20'h124, 20'h000, 1, 20'h114, 1, 1, 0);   // dropped
        add(0, 0, 1, 1, 1, 20'h128, 20'h200, 0, 20'h000, 0, 1, 0);   // flush -> 0x200
        add(0, 0, 0, 1, 1, 20'h114, 20'h000, 0, 20'h000, 0, 1, 1);   // stale
        add(0, 0, 0, 1, 1, 20'h118, 20'h000, 0, 20'h000, 0, 1, 2);   // stale
        add(0, 0, 0, 1, 0, 20'h200, 20'h000, 1, 20'h200, 0, 1, 2);   // target hit
        add(0, 0, 0, 0, 1, 20'h000, 20'h000, 0, 20'h000, 0, 1, 2);
        add(0, 0, 1, 1, 0, 20'h200, 20'h200, 0, 20'h000, 0, 1, 2);   // flush + same-cycle target
        add(0, 0, 0, 1, 0, 20'h200, 20'h000, 1, 20'h200, 0, 1, 2);   // accepted now
        add(0, 0, 0, 1, 0, 20'h204, 20'h000, 1, 20'h200, 1, 1, 2);
        add(0, 0, 0, 1, 0, 20'h208, 20'h000, 1, 20'h200, 1, 1, 2);   // count 3
        add(1, 0, 0, 1, 1, 20'h20C, 20'h000, 0, 20'h000, 1, 0, 0);   // reset mid-operation

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].iv, vecs[i].rdy, vecs[i].addr, vecs[i].tgt);
            report = (i == 12);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                          vecs[i].e_stall, vecs[i].e_ovf, vecs[i].e_disc);
        end
        report = 1'b0;

        seq_pc = 20'h400;
        for (int i = 0; i < 3000; i++) begin
            r_rst = (i == 0) || ($urandom_range(0, 299) == 0);
            r_st  = (mst == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_iv  = ($urandom_range(0, 9) < 7);
            r_rdy = ($urandom_range(0, 1) == 1);
            r_tgt = AW'($urandom_range(0, 255) * 4);
            if (mst == 2 && $urandom_range(0, 9) < 4) begin
                r_addr = m_exp;
            end else begin
                r_addr = seq_pc;
                seq_pc = seq_pc + 20'd4;
            end
            drive(r_rst, r_st, r_fl, r_iv, r_rdy, r_addr, r_tgt);
            model_step(r_rst, r_st, r_fl, r_iv, r_rdy, r_addr, r_tgt);
            tick();
            e_valid = (mst != 0) && (mq.size() > 0);
            check_outputs($sformatf("rnd%0d", i), e_valid, e_valid ? mq[0] : '0,
                          (mst == 0) || (mq.size() >= 2), m_ovf, m_disc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
